// File: rtl/wb_regfile.sv
// Write-back stage: mem-to-WB pipeline latch plus the 32-entry general register file.
// The latched entry commits into the array on the edge it leaves the latch; reads bypass it.
module wb_regfile #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wd_input,
    input  logic                  wreg_input,
    input  logic [DATA_WIDTH-1:0] wdata_input,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  re1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic                  re2,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic [ADDR_WIDTH-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [DATA_WIDTH-1:0] wb_wdata,
    output logic [31:0]           commit_count
);

    logic [DATA_WIDTH-1:0] regs [REG_NUM];
    logic                  replace;
    logic                  commit;

    // The entry leaves the latch whenever it is overwritten, including by a flush.
    assign replace = flush || !stall;
    assign commit  = replace && wb_wreg && (wb_wd != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_wd    <= '0;
            wb_wreg  <= 1'b0;
            wb_wdata <= '0;
        end else if (flush) begin
            wb_wd    <= '0;
            wb_wreg  <= 1'b0;
            wb_wdata <= '0;
        end else if (!stall) begin
            wb_wd    <= wd_input;
            wb_wreg  <= wreg_input;
            wb_wdata <= wdata_input;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb_wd] <= wb_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_count <= '0;
        end else if (commit) begin
            commit_count <= commit_count + 32'd1;
        end
    end

    // Register 0 reads as zero regardless of array contents or a pending WB entry.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic                  re,
        input logic [ADDR_WIDTH-1:0] raddr
    );
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        if (!reset && re && (raddr != '0)) begin
            if (wb_wreg && (raddr == wb_wd)) begin
                value = wb_wdata;
            end else begin
                value = regs[raddr];
            end
        end
        return value;
    endfunction

    always_comb begin
        rdata1 = '0;
        rdata1 = read_port(re1, raddr1);
    end

    always_comb begin
        rdata2 = '0;
        rdata2 = read_port(re2, raddr2);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: bypass, commit timing, stall/flush, r0 and async reset.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [4:0]  wd_input;
    logic        wreg_input;
    logic [31:0] wdata_input;
    logic        stall;
    logic        flush;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] commit_count;

    int total = 0;
    int bad   = 0;

    wb_regfile dut (
        .clk          (clk),
        .reset        (reset),
        .wd_input     (wd_input),
        .wreg_input   (wreg_input),
        .wdata_input  (wdata_input),
        .stall        (stall),
        .flush        (flush),
        .re1          (re1),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .re2          (re2),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .wb_wd        (wb_wd),
        .wb_wreg      (wb_wreg),
        .wb_wdata     (wb_wdata),
        .commit_count (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                 input logic st, input logic fl);
        wd_input    = wd;
        wreg_input  = wreg;
        wdata_input = wdata;
        stall       = st;
        flush       = fl;
    endtask

    task automatic setRead(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        re1    = e1;
        raddr1 = a1;
        re2    = e2;
        raddr2 = a2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        setRead(1'b1, 5'd5, 1'b1, 5'd31);
        checkOutput("reset_rdata1", rdata1, 32'h0);
        checkOutput("reset_rdata2", rdata2, 32'h0);
        #11;
        reset = 1'b0;
        #1;
        checkOutput("post_reset_rdata1", rdata1, 32'h0);
        checkOutput("post_reset_rdata2", rdata2, 32'h0);
        checkOutput("post_reset_count", commit_count, 32'd0);
        checkOutput("post_reset_wb_wreg", {31'd0, wb_wreg}, 32'd0);

        // Basic write: bypass after edge 1, array after edge 2.
        applyStimulus(5'd3, 1'b1, 32'h1234ABCD, 1'b0, 1'b0);
        tick();
        applyStimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        setRead(1'b1, 5'd3, 1'b1, 5'd3);
        checkOutput("bypass_r3_p1", rdata1, 32'h1234ABCD);
        checkOutput("bypass_r3_p2", rdata2, 32'h1234ABCD);
        checkOutput("bypass_wb_wd", {27'd0, wb_wd}, 32'd3);
        checkOutput("bypass_count", commit_count, 32'd0);
        tick();
        checkOutput("array_r3", rdata1, 32'h1234ABCD);
        checkOutput("array_wb_wreg", {31'd0, wb_wreg}, 32'd0);
        checkOutput("array_count", commit_count, 32'd1);

        // Register 0 is never written or counted; disabled port reads 0.
        applyStimulus(5'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        tick();
        applyStimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        setRead(1'b1, 5'd0, 1'b1, 5'd0);
        checkOutput("r0_pending_p1", rdata1, 32'h0);
        checkOutput("r0_pending_p2", rdata2, 32'h0);
        tick();
        checkOutput("r0_after_commit", rdata1, 32'h0);
        checkOutput("r0_count", commit_count, 32'd1);
        setRead(1'b0, 5'd3, 1'b1, 5'd3);
        checkOutput("re1_off", rdata1, 32'h0);
        checkOutput("re2_on_r3", rdata2, 32'h1234ABCD);

        // Stall holds the entry without committing; release commits exactly once.
        applyStimulus(5'd7, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        tick();
        applyStimulus(5'd8, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        setRead(1'b1, 5'd7, 1'b1, 5'd8);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("stall%0d_wb_wd", i), {27'd0, wb_wd}, 32'd7);
            checkOutput($sformatf("stall%0d_wb_wdata", i), wb_wdata, 32'hA5A5A5A5);
            checkOutput($sformatf("stall%0d_bypass", i), rdata1, 32'hA5A5A5A5);
            checkOutput($sformatf("stall%0d_r8", i), rdata2, 32'h0);
            checkOutput($sformatf("stall%0d_count", i), commit_count, 32'd1);
        end
        applyStimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("release_count", commit_count, 32'd2);
        checkOutput("release_r7", rdata1, 32'hA5A5A5A5);
        checkOutput("release_wb_wreg", {31'd0, wb_wreg}, 32'd0);
        tick();
        checkOutput("release_count_once", commit_count, 32'd2);

        // Flush wins over stall: entry commits, latch becomes NOP, new write dropped.
        applyStimulus(5'd9, 1'b1, 32'h00000011, 1'b0, 1'b0);
        tick();
        applyStimulus(5'd10, 1'b1, 32'h00000022, 1'b1, 1'b1);
        tick();
        applyStimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        setRead(1'b1, 5'd9, 1'b1, 5'd10);
        checkOutput("flush_r9", rdata1, 32'h00000011);
        checkOutput("flush_r10", rdata2, 32'h0);
        checkOutput("flush_wb_wd", {27'd0, wb_wd}, 32'd0);
        checkOutput("flush_wb_wreg", {31'd0, wb_wreg}, 32'd0);
        checkOutput("flush_wb_wdata", wb_wdata, 32'h0);
        checkOutput("flush_count", commit_count, 32'd3);
        tick();
        checkOutput("flush_r10_later", rdata2, 32'h0);
        checkOutput("flush_count_later", commit_count, 32'd3);

        // Back-to-back writes to one register: commit and load on the same edge.
        applyStimulus(5'd12, 1'b1, 32'h0000000C, 1'b0, 1'b0);
        tick();
        applyStimulus(5'd12, 1'b1, 32'h0000000D, 1'b0, 1'b0);
        tick();
        applyStimulus(5'd13, 1'b1, 32'h0000000E, 1'b0, 1'b0);
        setRead(1'b1, 5'd12, 1'b1, 5'd13);
        checkOutput("b2b_bypass_r12", rdata1, 32'h0000000D);
        checkOutput("b2b_count1", commit_count, 32'd4);
        tick();
        applyStimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("b2b_array_r12", rdata1, 32'h0000000D);
        checkOutput("b2b_bypass_r13", rdata2, 32'h0000000E);
        checkOutput("b2b_count2", commit_count, 32'd5);
        tick();
        checkOutput("b2b_count3", commit_count, 32'd6);

        // Async reset mid-cycle discards the pending entry.
        applyStimulus(5'd4, 1'b1, 32'h00000055, 1'b0, 1'b0);
        tick();
        applyStimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        setRead(1'b1, 5'd4, 1'b1, 5'd3);
        checkOutput("pre_reset_r4", rdata1, 32'h00000055);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_rdata1", rdata1, 32'h0);
        checkOutput("async_rdata2", rdata2, 32'h0);
        checkOutput("async_wb_wreg", {31'd0, wb_wreg}, 32'd0);
        checkOutput("async_wb_wdata", wb_wdata, 32'h0);
        checkOutput("async_count", commit_count, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("after_reset_r4", rdata1, 32'h0);
        checkOutput("after_reset_r3", rdata2, 32'h0);
        tick();
        checkOutput("after_reset_count", commit_count, 32'd0);
        checkOutput("after_reset_r4_edge", rdata1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
